// File: rtl/usrt_pkg.sv
// Shared USRT definitions: receiver FSM states, frame constants and parity helper.
package usrt_pkg;

  localparam int USRT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RESYNC
  } usrt_rx_state_t;

  // Expected parity bit: even parity when parity_type = 0, odd when 1.
  function automatic logic usrt_parity(input logic [USRT_DATA_BITS-1:0] data,
                                       input logic                      parity_type);
    return (^data) ^ parity_type;
  endfunction

endpackage

// File: rtl/usrt_receiver.sv
// USRT receiver: one line bit per clk, frame options latched at start bit,
// one-entry valid/ready output buffer with overrun reporting.
module usrt_receiver
  import usrt_pkg::*;
#(
  parameter int RXD_STAGES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_init,
  input  logic       ctrl_stop_bits,
  input  logic       ctrl_parity_ena,
  input  logic       ctrl_parity_type,
  input  logic       usrt_rxd,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       stat_overrun,
  output logic       stat_busy
);

  logic rxd_s;

  generate
    if (RXD_STAGES == 0) begin : g_nosync
      assign rxd_s = usrt_rxd;
    end else begin : g_sync
      logic [RXD_STAGES-1:0] rxd_q;
      // Stages reset to the idle-line level so no false start bit appears.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          rxd_q <= '1;
        else if (ctrl_init) rxd_q <= '1;
        else                rxd_q <= (rxd_q << 1) | RXD_STAGES'(usrt_rxd);
      end
      assign rxd_s = rxd_q[RXD_STAGES-1];
    end
  endgenerate

  usrt_rx_state_t              state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [USRT_DATA_BITS-1:0]   sh_q, sh_d;
  logic                        par_q, par_d;
  logic                        ferr_q, ferr_d;
  logic                        sidx_q, sidx_d;
  logic                        stop2_q, stop2_d;
  logic                        pena_q, pena_d;
  logic                        ptype_q, ptype_d;
  logic                        frame_done, frame_ferr, frame_perr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sidx_q  <= 1'b0;
      stop2_q <= 1'b0;
      pena_q  <= 1'b0;
      ptype_q <= 1'b0;
    end else if (ctrl_init) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sidx_q  <= 1'b0;
      stop2_q <= 1'b0;
      pena_q  <= 1'b0;
      ptype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      sidx_q  <= sidx_d;
      stop2_q <= stop2_d;
      pena_q  <= pena_d;
      ptype_q <= ptype_d;
    end
  end

  assign frame_ferr = ferr_q | ~rxd_s;
  assign frame_perr = pena_q & (par_q != usrt_parity(sh_q, ptype_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    sidx_d     = sidx_q;
    stop2_d    = stop2_q;
    pena_d     = pena_q;
    ptype_d    = ptype_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
          sidx_d  = 1'b0;
          stop2_d = ctrl_stop_bits;
          pena_d  = ctrl_parity_ena;
          ptype_d = ctrl_parity_type;
        end
      end
      ST_DATA: begin
        sh_d  = {rxd_s, sh_q[USRT_DATA_BITS-1:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(USRT_DATA_BITS - 1))
          state_d = pena_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        par_d   = rxd_s;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (stop2_q && !sidx_q) begin
          ferr_d = ~rxd_s;
          sidx_d = 1'b1;
        end else begin
          // Last stop bit: a low one must not be mistaken for the next start.
          frame_done = 1'b1;
          state_d    = frame_ferr ? ST_RESYNC : ST_IDLE;
        end
      end
      ST_RESYNC: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic buf_load, buf_pop, buf_ovr;

  assign buf_pop  = rx_valid & rx_ready;
  assign buf_load = frame_done & (~rx_valid | rx_ready);
  assign buf_ovr  = frame_done & rx_valid & ~rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data      <= '0;
      rx_perr      <= 1'b0;
      rx_ferr      <= 1'b0;
      rx_valid     <= 1'b0;
      stat_overrun <= 1'b0;
    end else if (ctrl_init) begin
      rx_data      <= '0;
      rx_perr      <= 1'b0;
      rx_ferr      <= 1'b0;
      rx_valid     <= 1'b0;
      stat_overrun <= 1'b0;
    end else begin
      stat_overrun <= buf_ovr;
      if (buf_load) begin
        rx_data  <= sh_q;
        rx_perr  <= frame_perr;
        rx_ferr  <= frame_ferr;
        rx_valid <= 1'b1;
      end else if (buf_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign stat_busy = (state_q != ST_IDLE);

endmodule

// File: doc/usrt_receiver.md
Name: usrt_receiver

Overview:
USRT receiver that recovers bytes from a serial line sampled once per clk, with no oversampling; line and clk are shared with the transmitter side. It is the downstream counterpart of the USRT transmitter. It accepts the same frame options (stop bits, parity enable, parity type) and delivers each byte with error flags on a valid/ready stream through a one-entry output buffer. Overrun is reported because the line cannot be back-pressured.

Parameters:
RXD_STAGES, 1, number of input register stages on usrt_rxd (0..3); each stage adds one cycle of latency.

Ports:
clk  input  1  clock; one line bit per rising edge
reset  input  1  asynchronous, active-high reset
ctrl_init  input  1  synchronous re-initialisation, same effect as reset
ctrl_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
ctrl_parity_ena  input  1  1 = parity bit present after D7
ctrl_parity_type  input  1  0 = even, 1 = odd
usrt_rxd  input  1  serial line, idle high
rx_data  output  8  received byte
rx_perr  output  1  parity error flag for rx_data
rx_ferr  output  1  framing error flag for rx_data (a stop bit was 0)
rx_valid  output  1  output buffer holds a word
rx_ready  input  1  consumer accepts the word
stat_overrun  output  1  one-cycle pulse: a completed frame was dropped because the buffer was full
stat_busy  output  1  high while the FSM is outside IDLE

Behaviour:
- Reset value of every output is 0. Input stages reset to 1 (idle line). FSM resets to IDLE.
- ctrl_init has priority over all other activity. It returns the block to the reset state in the next cycle, clears the buffer and drops any partial frame.
- Frame on the line, LSB first: start bit (0), D0..D7, P (only if parity enabled), stop1, stop2 (only if ctrl_stop_bits=1).
- ctrl_* are latched in the cycle the start bit is detected and held for the whole frame. Changing them mid-frame has no effect on that frame.
- Parity check:
  - expected P = ^data XOR parity_type.
  - perr = received P != expected P.
  - perr = 0 when parity is disabled.
- FSM states: IDLE, DATA, PARITY, STOP, RESYNC.
  - IDLE: sampled rxd=0 → DATA with bit counter = 0. Otherwise stay in IDLE.
  - DATA: shift the sampled bit into the data register MSB (right shift). When the counter reaches 7 → PARITY if parity is enabled, else → STOP.
  - PARITY: store P → STOP.
  - STOP: sample stop1, then stop2 if enabled. Any stop bit = 0 sets ferr. After the last stop bit, the frame completes:
    - ferr = 0 → IDLE.
    - ferr = 1 → RESYNC.
  - RESYNC: wait for sampled rxd=1, then → IDLE. A low stop bit is never taken as a start bit.
- Back-to-back frames with no idle bit between them are supported. The start bit in the cycle right after the last stop bit must be detected.
- Frame completion, i.e. the cycle the last stop bit is sampled:
  - If the buffer is empty, or rx_valid & rx_ready in that same cycle: rx_data, rx_perr and rx_ferr load and rx_valid = 1 in the next cycle.
  - Otherwise: the new frame is discarded, the buffered word is kept, and stat_overrun pulses high for one cycle.
- Latency from the sampled last stop bit on usrt_rxd to rx_valid = RXD_STAGES + 1 cycles.
- rx_valid deasserts the cycle after rx_valid & rx_ready, unless a new word loads in that same cycle. rx_data and flags are stable while rx_valid & ~rx_ready.
- A frame with a framing error is still delivered, with rx_ferr = 1.
- Reset or ctrl_init mid-frame: no word is delivered and no overrun is reported.

Decomposition:
- Package usrt_pkg:
  - FSM state enum (usrt_rx_state_t).
  - Constant USRT_DATA_BITS = 8.
  - Parity function usrt_parity(data, type); the transmitter may share it.
- No sub-module. The input register chain and the one-entry buffer are small enough to stay inline.

Test Plan:
- Byte 0xA5, 1 stop, no parity → rx_data=0xA5, perr=0, ferr=0; rx_valid exactly RXD_STAGES+1 cycles after the stop bit.
- Byte 0x3C, parity_ena=1, parity_type=1 (odd), P=1 → perr=0. Repeat with P=0 → perr=1, data still 0x3C.
- Two stop bits enabled, stop2 forced 0 → ferr=1 delivered. Then hold the line at 0 for 5 cycles → no new word; the next frame 0x11 is received after the line returns high.
- Frames 0x01, 0x02, 0x03 back-to-back with no idle bits and rx_ready=1 → three words in order, no overrun.
- rx_ready=0, send 0x55 then 0xAA → rx_data stays 0x55 and stat_overrun pulses once; then rx_ready=1 → 0x55 consumed and rx_valid falls.
- Assert ctrl_init in the middle of D4 of frame 0x77 → no word and no overrun; the next frame 0x88 is received correctly.
